// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Parametrised BCD stopwatch engine: start/stop/lap/clear control, internal
// tick prescaler, preset load, up/down counting with overflow and terminal
// detect, and a frozen lap display.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start_stop  pulse: IDLE->RUNNING, RUNNING<->PAUSED
//   lap         pulse: toggles lap freeze (freeze only while RUNNING)
//   clear       pulse: back to IDLE, count/prescaler/lap/overflow cleared
//   up_down     1 = count up, 0 = count down (sampled on each tick)
//   load        pulse: preset count from load_value (IDLE only)
//   load_value  BCD preset, digits above 9 are clamped to 9
//   number      displayed value (lap_reg while lap_active, else count)
//   running     high while RUNNING
//   lap_active  display frozen on lap_reg
//   overflow    sticky, set when an up-count wraps from all nines
//   done        one-cycle pulse when a down-count reaches zero
// -----------------------------------------------------------------------------
module stopwatch_core #(
   parameter int NUMBER_OF_DIGITS            = 4,
   parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int TICK_RATE_IN_HERTZ          = 100
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 start_stop,
   input  logic                                                 lap,
   input  logic                                                 clear,
   input  logic                                                 up_down,
   input  logic                                                 load,
   input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] load_value,
   output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
   output logic                                                 running,
   output logic                                                 lap_active,
   output logic                                                 overflow,
   output logic                                                 done
);

   localparam int W       = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
   localparam int B       = NUMBER_OF_BITS_PER_DIGIT;
   localparam int DIVIDER = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HERTZ;
   localparam int PW      = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;

   localparam logic [PW-1:0] PRESCALE_LAST = PW'(DIVIDER - 1);
   localparam logic [B-1:0]  DIGIT_NINE    = B'(9);
   localparam logic [B-1:0]  DIGIT_ZERO    = B'(0);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUNNING = 2'd1;
   localparam logic [1:0] PAUSED  = 2'd2;

   logic [1:0]    state, state_next;
   logic [PW-1:0] prescaler, prescaler_next;
   logic [W-1:0]  count, count_next;
   logic [W-1:0]  lap_reg, lap_next;
   logic          lap_active_next;
   logic          overflow_next;
   logic          done_next;

   // BCD increment with ripple carry; all nines wrap to all zeros.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      logic [B-1:0] d;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         d = v[i*B +: B];
         if (carry) begin
            if (d >= DIGIT_NINE) begin
               r[i*B +: B] = DIGIT_ZERO;
            end else begin
               r[i*B +: B] = d + B'(1);
               carry       = 1'b0;
            end
         end else begin
            r[i*B +: B] = d;
         end
      end
      return r;
   endfunction

   // BCD decrement with borrow; caller guarantees v is non-zero.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      logic [B-1:0] d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         d = v[i*B +: B];
         if (borrow) begin
            if (d == DIGIT_ZERO) begin
               r[i*B +: B] = DIGIT_NINE;
            end else begin
               r[i*B +: B] = d - B'(1);
               borrow      = 1'b0;
            end
         end else begin
            r[i*B +: B] = d;
         end
      end
      return r;
   endfunction

   // True when every digit holds 9 (next up-count wraps).
   function automatic logic bcd_all_nines(input logic [W-1:0] v);
      logic r;
      r = 1'b1;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         if (v[i*B +: B] != DIGIT_NINE) begin
            r = 1'b0;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Clamp each preset digit into the legal 0..9 range.
   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         r[i*B +: B] = (v[i*B +: B] > DIGIT_NINE) ? DIGIT_NINE : v[i*B +: B];
      end
      return r;
   endfunction

   // Next-state logic: at most one of clear / effective load / start_stop
   // acts per cycle, in that priority. A start_stop edge out of RUNNING
   // suppresses that cycle's prescaler step so the phase is held exactly.
   always_comb begin
      state_next      = state;
      prescaler_next  = prescaler;
      count_next      = count;
      lap_next        = lap_reg;
      lap_active_next = lap_active;
      overflow_next   = overflow;
      done_next       = 1'b0;
      if (clear) begin
         state_next      = IDLE;
         prescaler_next  = '0;
         count_next      = '0;
         lap_active_next = 1'b0;
         overflow_next   = 1'b0;
      end else if (load && (state == IDLE)) begin
         count_next    = bcd_clamp(load_value);
         overflow_next = 1'b0;
      end else if (start_stop) begin
         case (state)
            IDLE: begin
               // A down-count start from zero has nothing to count.
               if (!up_down && (count == '0)) begin
                  state_next = IDLE;
               end else begin
                  state_next     = RUNNING;
                  prescaler_next = '0;
               end
            end
            RUNNING: state_next = PAUSED;
            PAUSED:  state_next = RUNNING;
            default: state_next = IDLE;
         endcase
      end else begin
         if (lap) begin
            if (lap_active && (state != IDLE)) begin
               lap_active_next = 1'b0;
            end else if (!lap_active && (state == RUNNING)) begin
               lap_next        = count;
               lap_active_next = 1'b1;
            end else begin
               lap_active_next = lap_active;
            end
         end else begin
            lap_active_next = lap_active;
         end
         if (state == RUNNING) begin
            if (prescaler == PRESCALE_LAST) begin
               prescaler_next = '0;
               if (up_down) begin
                  count_next = bcd_inc(count);
                  if (bcd_all_nines(count)) begin
                     overflow_next = 1'b1;
                  end else begin
                     overflow_next = overflow;
                  end
               end else if (count == W'(1)) begin
                  count_next = '0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else if (count == '0) begin
                  // Direction flipped at zero: hold, never go negative.
                  state_next = IDLE;
               end else begin
                  count_next = bcd_dec(count);
               end
            end else begin
               prescaler_next = prescaler + PW'(1);
            end
         end else begin
            prescaler_next = prescaler;
         end
      end
   end

   // State and registered outputs; number is built from next-state values so
   // it shows the new count/lap value right after the update edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prescaler  <= '0;
         count      <= '0;
         lap_reg    <= '0;
         lap_active <= 1'b0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         running    <= 1'b0;
         number     <= '0;
      end else begin
         state      <= state_next;
         prescaler  <= prescaler_next;
         count      <= count_next;
         lap_reg    <= lap_next;
         lap_active <= lap_active_next;
         overflow   <= overflow_next;
         done       <= done_next;
         running    <= (state_next == RUNNING);
         number     <= lap_active_next ? lap_next : count_next;
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Directed self-checking bench for stopwatch_core with DIVIDER = 10.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

   logic        clk;
   logic        rst;
   logic        start_stop;
   logic        lap;
   logic        clear;
   logic        up_down;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] number;
   logic        running;
   logic        lap_active;
   logic        overflow;
   logic        done;

   int pass_count;
   int check_count;

   stopwatch_core #(
      .NUMBER_OF_DIGITS(4),
      .NUMBER_OF_BITS_PER_DIGIT(4),
      .BOARD_CLOCK_FREQUENCY_IN_HZ(10),
      .TICK_RATE_IN_HERTZ(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_stop(start_stop),
      .lap(lap),
      .clear(clear),
      .up_down(up_down),
      .load(load),
      .load_value(load_value),
      .number(number),
      .running(running),
      .lap_active(lap_active),
      .overflow(overflow),
      .done(done)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) begin
         pass_count++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_stop = 1'b1;
      cycles(1);
      start_stop = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      cycles(1);
      lap = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      load_value = v;
      load       = 1'b1;
      cycles(1);
      load       = 1'b0;
   endtask

   initial begin
      pass_count  = 0;
      check_count = 0;
      rst         = 1'b1;
      start_stop  = 1'b0;
      lap         = 1'b0;
      clear       = 1'b0;
      up_down     = 1'b1;
      load        = 1'b0;
      load_value  = 16'h0000;
      cycles(2);
      rst = 1'b0;

      // reset state
      check("rst_number", 32'(number), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_lap", 32'(lap_active), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_done", 32'(done), 32'h0);

      // start, up count: first increment on the 10th edge after the pulse
      pulse_start();
      check("up_running", 32'(running), 32'h1);
      check("up_hold0", 32'(number), 32'h0000);
      cycles(9);
      check("up_before_tick", 32'(number), 32'h0000);
      cycles(1);
      check("up_first_tick", 32'(number), 32'h0001);
      cycles(90);
      check("up_ten_ticks", 32'(number), 32'h0010);

      // pause at prescaler=6, hold, resume: next increment 4 cycles later
      cycles(6);
      pulse_start();
      check("pause_running", 32'(running), 32'h0);
      cycles(50);
      check("pause_hold", 32'(number), 32'h0010);
      pulse_start();
      check("resume_running", 32'(running), 32'h1);
      cycles(3);
      check("resume_3", 32'(number), 32'h0010);
      cycles(1);
      check("resume_4", 32'(number), 32'h0011);
      pulse_clear();
      check("clr_number", 32'(number), 32'h0000);
      check("clr_running", 32'(running), 32'h0);

      // wrap from 9999 sets sticky overflow
      do_load(16'h9998);
      check("load_9998", 32'(number), 32'h9998);
      pulse_start();
      cycles(10);
      check("wrap_9999", 32'(number), 32'h9999);
      check("wrap_no_ovf", 32'(overflow), 32'h0);
      cycles(10);
      check("wrap_0000", 32'(number), 32'h0000);
      check("wrap_ovf", 32'(overflow), 32'h1);
      cycles(10);
      check("wrap_0001", 32'(number), 32'h0001);
      check("wrap_ovf_sticky", 32'(overflow), 32'h1);
      check("wrap_running", 32'(running), 32'h1);
      pulse_clear();
      check("wrap_clr_ovf", 32'(overflow), 32'h0);
      check("wrap_clr_num", 32'(number), 32'h0000);
      check("wrap_clr_run", 32'(running), 32'h0);

      // down count to zero with done pulse
      do_load(16'h0002);
      up_down = 1'b0;
      pulse_start();
      cycles(10);
      check("down_0001", 32'(number), 32'h0001);
      check("down_no_done", 32'(done), 32'h0);
      cycles(9);
      check("down_hold1", 32'(number), 32'h0001);
      cycles(1);
      check("down_0000", 32'(number), 32'h0000);
      check("down_done", 32'(done), 32'h1);
      check("down_stopped", 32'(running), 32'h0);
      cycles(1);
      check("down_done_1cyc", 32'(done), 32'h0);
      pulse_start();
      check("down_start_ignored", 32'(running), 32'h0);
      cycles(15);
      check("down_still_0", 32'(number), 32'h0000);
      check("down_no_done2", 32'(done), 32'h0);

      // lap freeze while count advances underneath
      up_down = 1'b1;
      pulse_start();
      cycles(50);
      check("lap_pre", 32'(number), 32'h0005);
      pulse_lap();
      check("lap_active", 32'(lap_active), 32'h1);
      check("lap_frozen", 32'(number), 32'h0005);
      cycles(30);
      check("lap_still_frozen", 32'(number), 32'h0005);
      pulse_lap();
      check("lap_release", 32'(number), 32'h0008);
      check("lap_inactive", 32'(lap_active), 32'h0);
      pulse_clear();

      // clear beats start_stop in the same cycle
      clear      = 1'b1;
      start_stop = 1'b1;
      cycles(1);
      clear      = 1'b0;
      start_stop = 1'b0;
      check("prio_running", 32'(running), 32'h0);
      cycles(15);
      check("prio_number", 32'(number), 32'h0000);

      // digit clamping on load
      do_load(16'hFA37);
      check("clamp", 32'(number), 32'h9937);

      // load ignored while running
      pulse_start();
      do_load(16'h1234);
      cycles(10);
      check("load_ignored", 32'(number), 32'h9938);

      // reset mid-run
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("midrst_number", 32'(number), 32'h0000);
      check("midrst_running", 32'(running), 32'h0);
      check("midrst_lap", 32'(lap_active), 32'h0);
      check("midrst_ovf", 32'(overflow), 32'h0);
      cycles(20);
      check("midrst_idle", 32'(number), 32'h0000);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised BCD stopwatch engine; successor to the fixed 4-digit up/down counter that feeds the multiplexed seven-segment display.
- Adds start/stop/lap/clear control, an internal tick prescaler, preset load, down-count with terminal detect, and a frozen lap display.
- Sits between the debounced, edge-detected button pulses and the display driver; its `number` output connects directly to the digit display.

Parameters:
- NUMBER_OF_DIGITS, 4, number of BCD digits.
- NUMBER_OF_BITS_PER_DIGIT, 4, bits per digit. Must be ≥4; only values 0–9 are legal digit contents.
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency.
- TICK_RATE_IN_HERTZ, 100, count rate. DIVIDER = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HERTZ, which must be ≥2 and an exact integer.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- lap  in  1  one-cycle pulse; toggles lap freeze.
- clear  in  1  one-cycle pulse; returns to IDLE and zeroes the count.
- up_down  in  1  1 = count up, 0 = count down; sampled on every tick.
- load  in  1  one-cycle pulse; presets the count. Honoured only in IDLE.
- load_value  in  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  preset value, BCD per digit.
- number  out  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  displayed value: lap_reg when lap_active, otherwise count.
- running  out  1  high in RUNNING.
- lap_active  out  1  display is frozen.
- overflow  out  1  sticky; set on an up-count wrap.
- done  out  1  one-cycle pulse when a down-count reaches zero.

Behaviour:
- Reset: state=IDLE; count, lap_reg and prescaler = 0; all outputs 0.
- Inputs are registered-domain pulses; no internal synchronisation or debounce.
- States: IDLE, RUNNING, PAUSED.
  - IDLE + start_stop → RUNNING; prescaler cleared. Exception: up_down=0 with count=0 → start ignored, stays IDLE, no done.
  - RUNNING + start_stop → PAUSED; prescaler holds its phase.
  - PAUSED + start_stop → RUNNING; prescaler resumes from its held value.
  - Any state + clear → IDLE; count=0, prescaler=0, lap_active=0, overflow=0.
- Priority within a cycle: rst > clear > load > start_stop > lap. A lower-priority pulse in the same cycle as clear is discarded.
- Prescaler advances only in RUNNING and counts 0..DIVIDER-1. Tick occurs on the cycle it equals DIVIDER-1; it wraps to 0 the same cycle.
  - First tick after start is DIVIDER cycles after the start_stop pulse.
  - count updates on the clock edge following the tick cycle (latency 1).
- Up count, BCD ripple: digit 9 → 0 with carry to the next digit.
  - All digits 9 → all 0; overflow set; continues running.
- Down count, BCD borrow: digit 0 → 9 with borrow.
  - Tick with count==1 (LSB) and all other digits 0 → count=0, done pulses for 1 cycle in the same update, state → IDLE.
  - count never goes below zero.
- up_down may change while RUNNING; the direction takes effect on the next tick.
- Lap:
  - RUNNING + lap with lap_active=0 → lap_reg←count (value before any same-cycle tick update), lap_active=1.
  - lap with lap_active=1 → lap_active=0, in RUNNING or PAUSED.
  - PAUSED + lap with lap_active=0 → ignored. IDLE + lap → ignored.
  - Down-count reaching zero does not clear lap_active.
- Load (IDLE only): count←load_value, with each digit >9 clamped to 9. Also clears overflow. Ignored in RUNNING/PAUSED.
- number is registered-path consistent: it reflects the new count or lap_reg on the cycle after the update edge.
- rst mid-run: next edge behaves exactly as power-on reset.

Test Plan:
- Use BOARD_CLOCK_FREQUENCY_IN_HZ=10, TICK_RATE_IN_HERTZ=1 (DIVIDER=10), 4 digits.
- Start, up count: rst, then start_stop → number=0x0000 for 10 cycles, 0x0001 at cycle 11, 0x0010 after 10 ticks; running=1.
- Pause/resume phase: start, pause at prescaler=6, wait 50 cycles → number unchanged. Resume → next increment exactly 4 cycles later.
- Wrap: load 0x9998 in IDLE, start up → 0x9999 then 0x0000; overflow=1 and stays 1. clear → overflow=0, number=0x0000, IDLE.
- Down count: load 0x0002, up_down=0, start → 0x0001, then 0x0000 with done high for one cycle, running=0. A further start_stop with count=0 → stays IDLE.
- Lap: running at 0x0005, lap → number frozen at 0x0005, lap_active=1 while internal count advances. After 3 ticks, lap → number=0x0008, lap_active=0.
- Priority and clamping:
  - clear and start_stop in the same cycle in IDLE → remains IDLE, count=0.
  - load 0xFA37 → count=0x9937.
  - rst while RUNNING → all outputs 0 on the next edge.
